// File: rtl/idex_hazard_stage_if.sv
// Decode-to-execute bundle: ID-side instruction fields and front-end controls in,
// registered ID/EX fields, stall request and bubble counter out.
interface idex_hazard_stage_if #(
   parameter int XLEN = 32,
   parameter int CNTW = 16
);
   logic            ID_VALID;
   logic [4:0]      ID_RS;
   logic [4:0]      ID_RT;
   logic [4:0]      ID_RD;
   logic            ID_USES_RT;
   logic [XLEN-1:0] ID_RS_DATA;
   logic [XLEN-1:0] ID_RT_DATA;
   logic [XLEN-1:0] ID_IMM;
   logic [XLEN-1:0] ID_PC;
   logic            ID_RegWrite;
   logic            ID_MemRead;
   logic            ID_MemWrite;
   logic            ID_MemtoReg;
   logic            ID_ALUSrc;
   logic [3:0]      ID_ALUOP;
   logic            FLUSH;
   logic            MEM_STALL;

   logic            IDEX_VALID;
   logic [4:0]      IDEX_RS;
   logic [4:0]      IDEX_RT;
   logic [4:0]      IDEX_RD;
   logic [XLEN-1:0] IDEX_RS_DATA;
   logic [XLEN-1:0] IDEX_RT_DATA;
   logic [XLEN-1:0] IDEX_IMM;
   logic [XLEN-1:0] IDEX_PC;
   logic            IDEX_RegWrite;
   logic            IDEX_MemRead;
   logic            IDEX_MemWrite;
   logic            IDEX_MemtoReg;
   logic            IDEX_ALUSrc;
   logic [3:0]      IDEX_ALUOP;
   logic            STALL_IF_ID;
   logic [CNTW-1:0] STALL_CNT;

   modport master (
      output ID_VALID, ID_RS, ID_RT, ID_RD, ID_USES_RT,
             ID_RS_DATA, ID_RT_DATA, ID_IMM, ID_PC,
             ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_ALUOP,
             FLUSH, MEM_STALL,
      input  IDEX_VALID, IDEX_RS, IDEX_RT, IDEX_RD,
             IDEX_RS_DATA, IDEX_RT_DATA, IDEX_IMM, IDEX_PC,
             IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_MemtoReg, IDEX_ALUSrc, IDEX_ALUOP,
             STALL_IF_ID, STALL_CNT
   );

   modport slave (
      input  ID_VALID, ID_RS, ID_RT, ID_RD, ID_USES_RT,
             ID_RS_DATA, ID_RT_DATA, ID_IMM, ID_PC,
             ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_ALUOP,
             FLUSH, MEM_STALL,
      output IDEX_VALID, IDEX_RS, IDEX_RT, IDEX_RD,
             IDEX_RS_DATA, IDEX_RT_DATA, IDEX_IMM, IDEX_PC,
             IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_MemtoReg, IDEX_ALUSrc, IDEX_ALUOP,
             STALL_IF_ID, STALL_CNT
   );
endinterface

// File: rtl/idex_hazard_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush squashing
// (deferred across memory stalls) and a saturating bubble counter.
module idex_hazard_stage #(
   parameter int XLEN = 32,
   parameter int CNTW = 16
) (
   input logic               clk,
   input logic               rst_n,
   idex_hazard_stage_if.slave bus
);

   typedef struct packed {
      logic            valid;
      logic [4:0]      rs;
      logic [4:0]      rt;
      logic [4:0]      rd;
      logic [XLEN-1:0] rs_data;
      logic [XLEN-1:0] rt_data;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] pc;
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
      logic            mem_to_reg;
      logic            alu_src;
      logic [3:0]      alu_op;
   } idex_t;

   idex_t           idex_q, idex_d;
   logic            flush_pend_q, flush_pend_d;
   logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
   logic            load_use;

   function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   // Producer in EX is a load whose result the ID instruction actually reads.
   assign load_use = idex_q.valid && idex_q.mem_read && (idex_q.rd != 5'd0) &&
                     bus.ID_VALID &&
                     ((idex_q.rd == bus.ID_RS) ||
                      (bus.ID_USES_RT && (idex_q.rd == bus.ID_RT)));

   assign bus.STALL_IF_ID = bus.MEM_STALL | (load_use & ~bus.FLUSH & ~flush_pend_q);

   always_comb begin
      idex_d       = idex_q;
      flush_pend_d = flush_pend_q;
      stall_cnt_d  = stall_cnt_q;
      if (bus.MEM_STALL) begin
         if (bus.FLUSH) flush_pend_d = 1'b1;
      end else if (bus.FLUSH || flush_pend_q) begin
         idex_d       = '0;
         flush_pend_d = 1'b0;
      end else if (load_use) begin
         idex_d      = '0;
         stall_cnt_d = sat_inc(stall_cnt_q);
      end else begin
         idex_d.valid      = bus.ID_VALID;
         idex_d.rs         = bus.ID_RS;
         idex_d.rt         = bus.ID_RT;
         idex_d.rd         = bus.ID_RD;
         idex_d.rs_data    = bus.ID_RS_DATA;
         idex_d.rt_data    = bus.ID_RT_DATA;
         idex_d.imm        = bus.ID_IMM;
         idex_d.pc         = bus.ID_PC;
         // Forwarding never checks x0, so a write to it must not look live.
         idex_d.reg_write  = bus.ID_RegWrite & bus.ID_VALID & (bus.ID_RD != 5'd0);
         idex_d.mem_read   = bus.ID_MemRead & bus.ID_VALID;
         idex_d.mem_write  = bus.ID_MemWrite & bus.ID_VALID;
         idex_d.mem_to_reg = bus.ID_MemtoReg;
         idex_d.alu_src    = bus.ID_ALUSrc;
         idex_d.alu_op     = bus.ID_ALUOP;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idex_q       <= '0;
         flush_pend_q <= 1'b0;
         stall_cnt_q  <= '0;
      end else begin
         idex_q       <= idex_d;
         flush_pend_q <= flush_pend_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign bus.IDEX_VALID    = idex_q.valid;
   assign bus.IDEX_RS       = idex_q.rs;
   assign bus.IDEX_RT       = idex_q.rt;
   assign bus.IDEX_RD       = idex_q.rd;
   assign bus.IDEX_RS_DATA  = idex_q.rs_data;
   assign bus.IDEX_RT_DATA  = idex_q.rt_data;
   assign bus.IDEX_IMM      = idex_q.imm;
   assign bus.IDEX_PC       = idex_q.pc;
   assign bus.IDEX_RegWrite = idex_q.reg_write;
   assign bus.IDEX_MemRead  = idex_q.mem_read;
   assign bus.IDEX_MemWrite = idex_q.mem_write;
   assign bus.IDEX_MemtoReg = idex_q.mem_to_reg;
   assign bus.IDEX_ALUSrc   = idex_q.alu_src;
   assign bus.IDEX_ALUOP    = idex_q.alu_op;
   assign bus.STALL_CNT     = stall_cnt_q;

endmodule

// File: tb/tb_idex_hazard_stage.sv
// Directed bench for idex_hazard_stage: a CNTW=16 instance for the main scenarios
// and a CNTW=2 instance for counter saturation.
module tb_idex_hazard_stage;

   localparam int XLEN = 32;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   idex_hazard_stage_if #(.XLEN(XLEN), .CNTW(16)) bus ();
   idex_hazard_stage_if #(.XLEN(XLEN), .CNTW(2))  bus2 ();

   idex_hazard_stage #(.XLEN(XLEN), .CNTW(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
   idex_hazard_stage #(.XLEN(XLEN), .CNTW(2))  dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic uses_rt, input logic rw,
                            input logic mr, input logic mw);
      bus.ID_VALID    = v;
      bus.ID_RS       = rs;
      bus.ID_RT       = rt;
      bus.ID_RD       = rd;
      bus.ID_USES_RT  = uses_rt;
      bus.ID_RegWrite = rw;
      bus.ID_MemRead  = mr;
      bus.ID_MemWrite = mw;
      bus.ID_MemtoReg = mr;
      bus.ID_ALUSrc   = mr | mw;
      bus.ID_ALUOP    = 4'h2;
      bus.ID_RS_DATA  = 32'hA000_0000 | 32'(rs);
      bus.ID_RT_DATA  = 32'hB000_0000 | 32'(rt);
      bus.ID_IMM      = 32'h0000_0010 + 32'(rd);
      bus.ID_PC       = 32'h0000_1000 + (32'(rd) << 2);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.FLUSH = 1'b0;
      bus.MEM_STALL = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.ID_VALID    = 1'($urandom);
         bus.ID_RS       = 5'($urandom);
         bus.ID_RT       = 5'($urandom);
         bus.ID_RD       = 5'($urandom);
         bus.ID_USES_RT  = 1'($urandom);
         bus.ID_RegWrite = 1'($urandom);
         bus.ID_MemRead  = 1'($urandom);
         bus.ID_MemWrite = 1'($urandom);
         bus.ID_MemtoReg = 1'($urandom);
         bus.ID_ALUSrc   = 1'($urandom);
         bus.ID_ALUOP    = 4'($urandom);
         bus.ID_RS_DATA  = $urandom;
         bus.ID_RT_DATA  = $urandom;
         bus.ID_IMM      = $urandom;
         bus.ID_PC       = $urandom;
         tick();
      end
      n_checks++; if (bus.IDEX_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.IDEX_VALID); end
      n_checks++; if (bus.IDEX_RD !== 5'd0) begin n_fail++; $display("FAIL reset_rd: got %0d want 0", bus.IDEX_RD); end
      n_checks++; if (bus.IDEX_RS_DATA !== 32'h0) begin n_fail++; $display("FAIL reset_rs_data: got %h want 0", bus.IDEX_RS_DATA); end
      n_checks++; if (bus.IDEX_PC !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", bus.IDEX_PC); end
      n_checks++; if (bus.IDEX_RegWrite !== 1'b0 || bus.IDEX_MemRead !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl: got rw=%b mr=%b want 0 0", bus.IDEX_RegWrite, bus.IDEX_MemRead); end
      n_checks++; if (bus.STALL_CNT !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", bus.STALL_CNT); end
      n_checks++; if (bus.STALL_IF_ID !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", bus.STALL_IF_ID); end
   endtask

   task automatic test_normal();
      rst_n = 1'b1;
      set_instr(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      n_checks++; if (bus.IDEX_RD !== 5'd3 || bus.IDEX_RS !== 5'd1 || bus.IDEX_RT !== 5'd2) begin n_fail++; $display("FAIL normal_idx: got rd=%0d rs=%0d rt=%0d want 3 1 2", bus.IDEX_RD, bus.IDEX_RS, bus.IDEX_RT); end
      n_checks++; if (bus.IDEX_RegWrite !== 1'b1 || bus.IDEX_VALID !== 1'b1) begin n_fail++; $display("FAIL normal_ctrl: got rw=%b v=%b want 1 1", bus.IDEX_RegWrite, bus.IDEX_VALID); end
      n_checks++; if (bus.IDEX_RS_DATA !== 32'hA000_0001 || bus.IDEX_RT_DATA !== 32'hB000_0002) begin n_fail++; $display("FAIL normal_data: got %h %h want a0000001 b0000002", bus.IDEX_RS_DATA, bus.IDEX_RT_DATA); end
      n_checks++; if (bus.IDEX_IMM !== 32'h13 || bus.IDEX_PC !== 32'h100C || bus.IDEX_ALUOP !== 4'h2) begin n_fail++; $display("FAIL normal_imm_pc: got %h %h %h want 13 100c 2", bus.IDEX_IMM, bus.IDEX_PC, bus.IDEX_ALUOP); end
      set_instr(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      n_checks++; if (bus.IDEX_RegWrite !== 1'b0 || bus.IDEX_VALID !== 1'b1) begin n_fail++; $display("FAIL normal_x0: got rw=%b v=%b want 0 1", bus.IDEX_RegWrite, bus.IDEX_VALID); end
      set_instr(1'b0, 5'd7, 5'd8, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1);
      tick();
      n_checks++; if (bus.IDEX_VALID !== 1'b0 || bus.IDEX_RegWrite !== 1'b0 || bus.IDEX_MemRead !== 1'b0 || bus.IDEX_MemWrite !== 1'b0) begin n_fail++; $display("FAIL invalid_ctrl: got v=%b rw=%b mr=%b mw=%b want 0 0 0 0", bus.IDEX_VALID, bus.IDEX_RegWrite, bus.IDEX_MemRead, bus.IDEX_MemWrite); end
      n_checks++; if (bus.IDEX_RD !== 5'd4 || bus.IDEX_RS_DATA !== 32'hA000_0007) begin n_fail++; $display("FAIL invalid_fields: got rd=%0d data=%h want 4 a0000007", bus.IDEX_RD, bus.IDEX_RS_DATA); end
   endtask

   task automatic test_load_use();
      set_instr(1'b1, 5'd1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      set_instr(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0);
      #1;
      n_checks++; if (bus.STALL_IF_ID !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %b want 1", bus.STALL_IF_ID); end
      tick();
      n_checks++; if (bus.IDEX_VALID !== 1'b0 || bus.IDEX_RD !== 5'd0 || bus.IDEX_RS_DATA !== 32'h0 || bus.IDEX_PC !== 32'h0) begin n_fail++; $display("FAIL lu_bubble: got v=%b rd=%0d data=%h pc=%h want all 0", bus.IDEX_VALID, bus.IDEX_RD, bus.IDEX_RS_DATA, bus.IDEX_PC); end
      n_checks++; if (bus.STALL_CNT !== 16'd1) begin n_fail++; $display("FAIL lu_cnt: got %0d want 1", bus.STALL_CNT); end
      n_checks++; if (bus.STALL_IF_ID !== 1'b0) begin n_fail++; $display("FAIL lu_one_cycle: got %b want 0", bus.STALL_IF_ID); end
      tick();
      n_checks++; if (bus.IDEX_RD !== 5'd6 || bus.IDEX_VALID !== 1'b1) begin n_fail++; $display("FAIL lu_resume: got rd=%0d v=%b want 6 1", bus.IDEX_RD, bus.IDEX_VALID); end
      // Load targeting x0 never stalls.
      set_instr(1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      set_instr(1'b1, 5'd0, 5'd7, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0);
      #1;
      n_checks++; if (bus.STALL_IF_ID !== 1'b0) begin n_fail++; $display("FAIL lu_x0_stall: got %b want 0", bus.STALL_IF_ID); end
      tick();
      n_checks++; if (bus.IDEX_RD !== 5'd6 || bus.IDEX_VALID !== 1'b1) begin n_fail++; $display("FAIL lu_x0_capture: got rd=%0d v=%b want 6 1", bus.IDEX_RD, bus.IDEX_VALID); end
      // RT matches the load but is not read.
      set_instr(1'b1, 5'd1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      set_instr(1'b1, 5'd2, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      #1;
      n_checks++; if (bus.STALL_IF_ID !== 1'b0) begin n_fail++; $display("FAIL lu_no_rt_stall: got %b want 0", bus.STALL_IF_ID); end
      tick();
      n_checks++; if (bus.IDEX_MemWrite !== 1'b1 || bus.IDEX_VALID !== 1'b1 || bus.STALL_CNT !== 16'd1) begin n_fail++; $display("FAIL lu_no_rt_capture: got mw=%b v=%b cnt=%0d want 1 1 1", bus.IDEX_MemWrite, bus.IDEX_VALID, bus.STALL_CNT); end
      // RT dependency with ID_USES_RT does stall.
      set_instr(1'b1, 5'd1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      set_instr(1'b1, 5'd7, 5'd5, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
      #1;
      n_checks++; if (bus.STALL_IF_ID !== 1'b1) begin n_fail++; $display("FAIL lu_rt_stall: got %b want 1", bus.STALL_IF_ID); end
      tick();
      n_checks++; if (bus.STALL_CNT !== 16'd2 || bus.IDEX_VALID !== 1'b0) begin n_fail++; $display("FAIL lu_rt_bubble: got cnt=%0d v=%b want 2 0", bus.STALL_CNT, bus.IDEX_VALID); end
      tick();
   endtask

   task automatic test_flush_vs_load_use();
      set_instr(1'b1, 5'd1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      set_instr(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0);
      bus.FLUSH = 1'b1;
      #1;
      n_checks++; if (bus.STALL_IF_ID !== 1'b0) begin n_fail++; $display("FAIL flush_lu_stall: got %b want 0", bus.STALL_IF_ID); end
      tick();
      bus.FLUSH = 1'b0;
      n_checks++; if (bus.IDEX_VALID !== 1'b0 || bus.IDEX_RD !== 5'd0 || bus.IDEX_RS_DATA !== 32'h0) begin n_fail++; $display("FAIL flush_lu_bubble: got v=%b rd=%0d data=%h want 0 0 0", bus.IDEX_VALID, bus.IDEX_RD, bus.IDEX_RS_DATA); end
      n_checks++; if (bus.STALL_CNT !== 16'd2) begin n_fail++; $display("FAIL flush_lu_cnt: got %0d want 2", bus.STALL_CNT); end
   endtask

   task automatic test_flush_mem_stall();
      set_instr(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      set_instr(1'b1, 5'd3, 5'd4, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0);
      bus.MEM_STALL = 1'b1;
      bus.FLUSH = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++; if (bus.STALL_IF_ID !== 1'b1) begin n_fail++; $display("FAIL ms_stall[%0d]: got %b want 1", i, bus.STALL_IF_ID); end
         tick();
         n_checks++; if (bus.IDEX_RD !== 5'd9 || bus.IDEX_VALID !== 1'b1) begin n_fail++; $display("FAIL ms_hold[%0d]: got rd=%0d v=%b want 9 1", i, bus.IDEX_RD, bus.IDEX_VALID); end
      end
      bus.MEM_STALL = 1'b0;
      bus.FLUSH = 1'b0;
      tick();
      n_checks++; if (bus.IDEX_VALID !== 1'b0 || bus.IDEX_RD !== 5'd0) begin n_fail++; $display("FAIL ms_pending_bubble: got v=%b rd=%0d want 0 0", bus.IDEX_VALID, bus.IDEX_RD); end
      tick();
      n_checks++; if (bus.IDEX_RD !== 5'd10 || bus.IDEX_VALID !== 1'b1) begin n_fail++; $display("FAIL ms_resume: got rd=%0d v=%b want 10 1", bus.IDEX_RD, bus.IDEX_VALID); end
   endtask

   task automatic test_reset_mid_flush();
      bus.MEM_STALL = 1'b1;
      bus.FLUSH = 1'b1;
      tick();
      rst_n = 1'b0;
      bus.MEM_STALL = 1'b0;
      bus.FLUSH = 1'b0;
      tick();
      n_checks++; if (bus.STALL_CNT !== 16'd0 || bus.IDEX_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_mid_clear: got cnt=%0d v=%b want 0 0", bus.STALL_CNT, bus.IDEX_VALID); end
      rst_n = 1'b1;
      set_instr(1'b1, 5'd1, 5'd2, 5'd11, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      n_checks++; if (bus.IDEX_RD !== 5'd11 || bus.IDEX_VALID !== 1'b1) begin n_fail++; $display("FAIL rst_mid_capture: got rd=%0d v=%b want 11 1", bus.IDEX_RD, bus.IDEX_VALID); end
   endtask

   task automatic test_saturation();
      logic [1:0] exp_cnt;
      for (int i = 0; i < 5; i++) begin
         bus2.ID_VALID = 1'b1; bus2.ID_RS = 5'd1; bus2.ID_RT = 5'd0; bus2.ID_RD = 5'd5;
         bus2.ID_USES_RT = 1'b0; bus2.ID_RegWrite = 1'b1; bus2.ID_MemRead = 1'b1;
         tick();
         bus2.ID_RS = 5'd5; bus2.ID_RT = 5'd7; bus2.ID_RD = 5'd6;
         bus2.ID_USES_RT = 1'b1; bus2.ID_MemRead = 1'b0;
         tick();
         exp_cnt = (i < 3) ? 2'(i + 1) : 2'd3;
         n_checks++; if (bus2.STALL_CNT !== exp_cnt) begin n_fail++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, bus2.STALL_CNT, exp_cnt); end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      bus.FLUSH = 1'b0;
      bus.MEM_STALL = 1'b0;
      bus2.ID_VALID = 1'b0; bus2.ID_RS = 5'd0; bus2.ID_RT = 5'd0; bus2.ID_RD = 5'd0;
      bus2.ID_USES_RT = 1'b0; bus2.ID_RS_DATA = '0; bus2.ID_RT_DATA = '0;
      bus2.ID_IMM = '0; bus2.ID_PC = '0; bus2.ID_RegWrite = 1'b0; bus2.ID_MemRead = 1'b0;
      bus2.ID_MemWrite = 1'b0; bus2.ID_MemtoReg = 1'b0; bus2.ID_ALUSrc = 1'b0;
      bus2.ID_ALUOP = 4'h0; bus2.FLUSH = 1'b0; bus2.MEM_STALL = 1'b0;
      test_reset();
      test_normal();
      test_load_use();
      test_flush_vs_load_use();
      test_flush_mem_stall();
      test_reset_mid_flush();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/idex_hazard_stage.md
Name: idex_hazard_stage

Overview:
- ID/EX pipeline register with load-use hazard detection and bubble/flush insertion for the 5-stage RISC-V core.
- Sits between decode and execute.
- Produces the IDEX_RS/IDEX_RT/IDEX_RD and control fields consumed by the forwarding unit and the EX operand muxes.
- Drives the stall back to the PC and IF/ID register.

Parameters:
- XLEN, 32, datapath width for register data, immediate and PC.
- CNTW, 16, width of the stall performance counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- ID_VALID  input  1  decode stage holds a real instruction.
- ID_RS  input  5  source register 1 index.
- ID_RT  input  5  source register 2 index.
- ID_RD  input  5  destination register index.
- ID_USES_RT  input  1  instruction reads RT (R-type, store, branch).
- ID_RS_DATA  input  XLEN  register file read data 1.
- ID_RT_DATA  input  XLEN  register file read data 2.
- ID_IMM  input  XLEN  sign-extended immediate.
- ID_PC  input  XLEN  instruction PC.
- ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc  input  1 each  decoded control.
- ID_ALUOP  input  4  ALU operation.
- FLUSH  input  1  branch/jump resolved taken in EX; squash the ID instruction.
- MEM_STALL  input  1  data memory busy; freeze the whole front end.
- IDEX_VALID  output  1  registered valid.
- IDEX_RS, IDEX_RT, IDEX_RD  output  5 each  registered indices.
- IDEX_RS_DATA, IDEX_RT_DATA, IDEX_IMM, IDEX_PC  output  XLEN each  registered data.
- IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_MemtoReg, IDEX_ALUSrc  output  1 each.
- IDEX_ALUOP  output  4.
- STALL_IF_ID  output  1  combinational; hold PC and IF/ID this cycle.
- STALL_CNT  output  CNTW  saturating count of load-use bubbles inserted.

Behaviour:
- Reset (rst_n=0 at clk edge): all IDEX_* outputs, flush_pending and STALL_CNT cleared to 0. Reset mid-stall or mid-flush discards that state.
- load_use is combinational and is 1 when all of the following hold:
  - IDEX_VALID && IDEX_MemRead
  - IDEX_RD != 0
  - ID_VALID
  - (IDEX_RD == ID_RS) or (ID_USES_RT && IDEX_RD == ID_RT)
- STALL_IF_ID = MEM_STALL | (load_use & ~FLUSH & ~flush_pending).
- Per-edge priority, highest first:
  1. MEM_STALL=1: all IDEX_* registers hold. If FLUSH=1, set flush_pending=1.
  2. FLUSH=1 or flush_pending=1: load a bubble, clear flush_pending.
  3. load_use=1: load a bubble, STALL_CNT += 1 (saturates at all-ones, never wraps).
  4. Otherwise capture all ID_* inputs; IDEX_VALID = ID_VALID.
- Bubble: every IDEX_* output = 0, including the data fields.
- ID_VALID=0 capture: control bits forced 0 (RegWrite, MemRead, MemWrite); index and data fields still captured.
- x0 suppression on capture: IDEX_RegWrite = ID_RegWrite & (ID_RD != 0). The forwarding unit relies on this because it does not check register 0.
- Latency: one cycle from ID inputs to IDEX outputs.
- A load-use stall lasts exactly one cycle. Next cycle IDEX holds a bubble, load_use deasserts, and the held ID instruction is captured.
- Load followed by an instruction that does not use RT, where the load RD equals the ID RT: no stall.

Test Plan:
- Reset: rst_n=0 for 2 cycles with random inputs → all IDEX_* = 0, STALL_CNT=0, STALL_IF_ID=0 (MEM_STALL=0).
- Normal flow: ID add x3,x1,x2 (RegWrite=1) → next cycle IDEX_RD=3, IDEX_RS=1, IDEX_RT=2, IDEX_RegWrite=1, IDEX_VALID=1. With ID_RD=0 → IDEX_RegWrite=0.
- Load-use: IDEX holds lw x5 (MemRead=1, VALID=1); ID add x6,x5,x7 → STALL_IF_ID=1 for 1 cycle, then IDEX bubble (all 0), STALL_CNT=1. The following cycle IDEX_RD=6.
  - Same case with lw x0 → no stall.
  - Same case with a sw that has RT=x5 but ID_USES_RT=0 → no stall.
- Flush vs load-use: load_use and FLUSH both 1 → STALL_IF_ID=0, bubble inserted, STALL_CNT unchanged.
- Flush under MEM_STALL: FLUSH=1 while MEM_STALL=1 for 3 cycles → IDEX holds its value for all 3 cycles. On the first cycle with MEM_STALL=0, a bubble is inserted even though FLUSH=0.
- Counter saturation: preload via 65535 load-use events (or a reduced-CNTW build with CNTW=2, 5 events) → STALL_CNT stops at all-ones.
